// File: rtl/vx_branch_resolve_pkg.sv
// Shared GPU types for the branch-resolve slice: warp branch state, widths.
// NUM_WARPS / NUM_ALU_BLOCKS fall back to 8 / 4 when the build does not set them.
`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif
`ifndef NUM_ALU_BLOCKS
`define NUM_ALU_BLOCKS 4
`endif

package VX_gpu_pkg;
  localparam int NW_WIDTH = (`NUM_WARPS > 1) ? $clog2(`NUM_WARPS) : 1;
  localparam int PC_BITS  = 32;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_WAIT  = 2'd1,
    WS_REDIR = 2'd2
  } warp_state_e;
endpackage

// File: rtl/vx_branch_ctl_if.sv
// Resolved-branch report from one ALU block; fire-and-forget, no backpressure.
interface VX_branch_ctl_if;
  import VX_gpu_pkg::*;
  logic                valid;
  logic [NW_WIDTH-1:0] wid;
  logic                taken;
  logic [PC_BITS-1:0]  dest;

  modport master (output valid, wid, taken, dest);
  modport slave  (input  valid, wid, taken, dest);
endinterface

// File: rtl/vx_branch_resolve_arb.sv
// Round-robin arbiter; once a grant is shown but not taken it stays locked so
// late-arriving requests cannot change the presented index.
module VX_rr_arbiter #(
  parameter  int NUM_REQS = 4,
  localparam int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REQS-1:0] requests_i,
  input  logic                grant_ready_i,
  output logic [IDXW-1:0]     grant_index_o,
  output logic                grant_valid_o
);
  logic [IDXW-1:0] ptr_q, lock_idx_q, pick;
  logic            locked_q, found;
  int              idx;

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQS;
      if (!found && requests_i[idx]) begin
        found = 1'b1;
        pick  = IDXW'(idx);
      end
    end
  end

  assign grant_valid_o = |requests_i;
  assign grant_index_o = locked_q ? lock_idx_q : pick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      locked_q   <= grant_valid_o && !grant_ready_i;
      lock_idx_q <= grant_index_o;
      if (grant_valid_o && grant_ready_i)
        ptr_q <= (int'(grant_index_o) == NUM_REQS - 1) ? '0 : grant_index_o + 1'b1;
    end
  end
endmodule

// File: rtl/vx_branch_resolve.sv
// Per-warp branch stall/resolve/redirect tracker with round-robin redirect issue.
// Optional perf counters when BRANCH_RESOLVE_PERF_EN is defined.
`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif
`ifndef NUM_ALU_BLOCKS
`define NUM_ALU_BLOCKS 4
`endif

module vx_branch_resolve
  import VX_gpu_pkg::*;
#(
  parameter int    NUM_WARPS   = `NUM_WARPS,
  parameter int    NUM_BLOCKS  = `NUM_ALU_BLOCKS,
  parameter string INSTANCE_ID = ""
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  VX_branch_ctl_if.slave       branch_ctl_if [NUM_BLOCKS],
  input  logic                 stall_valid_i,
  input  logic [NW_WIDTH-1:0]  stall_wid_i,
  output logic                 redir_valid_o,
  input  logic                 redir_ready_i,
  output logic [NW_WIDTH-1:0]  redir_wid_o,
  output logic [PC_BITS-1:0]   redir_pc_o,
  output logic [NUM_WARPS-1:0] stalled_mask_o,
  output logic                 protocol_err_o
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [63:0]          perf_taken_o,
  output logic [63:0]          perf_not_taken_o,
  output logic [63:0]          perf_redir_stall_o
`endif
);
  logic [NUM_BLOCKS-1:0] blk_valid, blk_taken;
  logic [NW_WIDTH-1:0]   blk_wid  [NUM_BLOCKS];
  logic [PC_BITS-1:0]    blk_dest [NUM_BLOCKS];

  logic [NUM_WARPS-1:0] redir_req, mask_d, mask_q, warp_err, acc_taken;
  logic [PC_BITS-1:0]   dest_arr [NUM_WARPS];
  logic [NW_WIDTH-1:0]  grant_idx;
  logic                 redir_fire, protocol_err_q;

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
    assign blk_valid[gi] = branch_ctl_if[gi].valid;
    assign blk_wid[gi]   = branch_ctl_if[gi].wid;
    assign blk_taken[gi] = branch_ctl_if[gi].taken;
    assign blk_dest[gi]  = branch_ctl_if[gi].dest;
  end

  assign redir_fire = redir_valid_o && redir_ready_i;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    warp_state_e        state_q, state_d;
    logic [PC_BITS-1:0] dest_q, res_dest;
    logic               res_hit, res_taken, res_multi, stall_hit, grant_hit;

    // Scan high-to-low so the lowest reporting block is the one that sticks.
    always_comb begin
      res_hit   = 1'b0;
      res_taken = 1'b0;
      res_multi = 1'b0;
      res_dest  = '0;
      for (int b = NUM_BLOCKS - 1; b >= 0; b--) begin
        if (blk_valid[b] && blk_wid[b] == NW_WIDTH'(gi)) begin
          res_multi = res_multi | res_hit;
          res_hit   = 1'b1;
          res_taken = blk_taken[b];
          res_dest  = blk_dest[b];
        end
      end
    end

    assign stall_hit = stall_valid_i && (stall_wid_i == NW_WIDTH'(gi));
    assign grant_hit = redir_fire && (grant_idx == NW_WIDTH'(gi));

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        WS_IDLE:  if (stall_hit && !res_hit) state_d = WS_WAIT;
        WS_WAIT:  if (res_hit) state_d = res_taken ? WS_REDIR : WS_IDLE;
        WS_REDIR: if (grant_hit) state_d = WS_IDLE;
        default:  state_d = WS_IDLE;
      endcase
    end

    assign acc_taken[gi] = (state_q == WS_WAIT) && res_hit && res_taken;
    assign warp_err[gi]  = res_multi || (res_hit && state_q != WS_WAIT) ||
                           (stall_hit && (state_q != WS_IDLE || res_hit));
    assign redir_req[gi] = (state_q == WS_REDIR);
    assign mask_d[gi]    = (state_d != WS_IDLE);
    assign dest_arr[gi]  = dest_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= WS_IDLE;
      else         state_q <= state_d;
    end

    // Target only matters while in REDIR, so it carries no reset.
    always_ff @(posedge clk_i) begin
      if (acc_taken[gi]) dest_q <= res_dest;
    end
  end

  VX_rr_arbiter #(.NUM_REQS(NUM_WARPS)) u_arb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .requests_i    (redir_req),
    .grant_ready_i (redir_ready_i),
    .grant_index_o (grant_idx),
    .grant_valid_o (redir_valid_o)
  );

  assign redir_wid_o    = grant_idx;
  assign redir_pc_o     = dest_arr[grant_idx];
  assign stalled_mask_o = mask_q;
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q         <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      mask_q         <= mask_d;
      protocol_err_q <= protocol_err_q | (|warp_err);
    end
  end

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [NUM_WARPS-1:0] acc_not_taken;
  logic [63:0]          perf_taken_q, perf_not_taken_q, perf_redir_stall_q;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_perf
    assign acc_not_taken[gi] = (g_warp[gi].state_q == WS_WAIT) &&
                               g_warp[gi].res_hit && !g_warp[gi].res_taken;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_taken_q       <= '0;
      perf_not_taken_q   <= '0;
      perf_redir_stall_q <= '0;
    end else begin
      perf_taken_q     <= perf_taken_q + 64'($countones(acc_taken));
      perf_not_taken_q <= perf_not_taken_q + 64'($countones(acc_not_taken));
      if (redir_valid_o && !redir_ready_i) perf_redir_stall_q <= perf_redir_stall_q + 64'd1;
    end
  end

  assign perf_taken_o       = perf_taken_q;
  assign perf_not_taken_o   = perf_not_taken_q;
  assign perf_redir_stall_o = perf_redir_stall_q;
`endif
endmodule

// File: tb/tb_vx_branch_resolve.sv
// Scoreboard bench: expected redirects queued at stimulus, checked on each accepted redirect.
module tb_vx_branch_resolve;
  import VX_gpu_pkg::*;

  localparam int NW = 8;
  localparam int NB = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                stall_valid_i, redir_ready_i;
  logic [NW_WIDTH-1:0] stall_wid_i;
  logic                redir_valid_o, protocol_err_o;
  logic [NW_WIDTH-1:0] redir_wid_o;
  logic [PC_BITS-1:0]  redir_pc_o;
  logic [NW-1:0]       stalled_mask_o;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [63:0] perf_taken_o, perf_not_taken_o, perf_redir_stall_o;
`endif

  logic                b_valid [NB];
  logic [NW_WIDTH-1:0] b_wid   [NB];
  logic                b_taken [NB];
  logic [PC_BITS-1:0]  b_dest  [NB];

  VX_branch_ctl_if bctl [NB] ();
  for (genvar gi = 0; gi < NB; gi++) begin : g_drv
    assign bctl[gi].valid = b_valid[gi];
    assign bctl[gi].wid   = b_wid[gi];
    assign bctl[gi].taken = b_taken[gi];
    assign bctl[gi].dest  = b_dest[gi];
  end

  vx_branch_resolve #(.NUM_WARPS(NW), .NUM_BLOCKS(NB), .INSTANCE_ID("tb")) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .branch_ctl_if  (bctl),
    .stall_valid_i  (stall_valid_i),
    .stall_wid_i    (stall_wid_i),
    .redir_valid_o  (redir_valid_o),
    .redir_ready_i  (redir_ready_i),
    .redir_wid_o    (redir_wid_o),
    .redir_pc_o     (redir_pc_o),
    .stalled_mask_o (stalled_mask_o),
    .protocol_err_o (protocol_err_o)
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    .perf_taken_o       (perf_taken_o),
    .perf_not_taken_o   (perf_not_taken_o),
    .perf_redir_stall_o (perf_redir_stall_o)
`endif
  );

  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic [PC_BITS-1:0]  pc;
  } redir_t;

  redir_t exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Every accepted redirect must match the oldest queued expectation.
  always @(negedge clk_i) begin
    redir_t e;
    if (rst_ni && redir_valid_o && redir_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 64'({redir_wid_o, redir_pc_o}), '1);
      end else begin
        e = exp_q.pop_front();
        $display("redir wid=%0d pc=0x%08h (want wid=%0d pc=0x%08h)", redir_wid_o, redir_pc_o, e.wid, e.pc);
        chk("sb_wid", 64'(redir_wid_o), 64'(e.wid));
        chk("sb_pc", 64'(redir_pc_o), 64'(e.pc));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_valid_i = 1'b0;
    stall_wid_i   = '0;
    for (int b = 0; b < NB; b++) begin
      b_valid[b] = 1'b0;
      b_wid[b]   = '0;
      b_taken[b] = 1'b0;
      b_dest[b]  = '0;
    end
  endtask

  task automatic do_reset();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst_ni = 1'b0;
    idle_inputs();
    redir_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic stall(input int wid);
    stall_valid_i = 1'b1;
    stall_wid_i   = NW_WIDTH'(wid);
  endtask

  task automatic resolve(input int b, input int wid, input bit taken, input logic [31:0] dest);
    b_valid[b] = 1'b1;
    b_wid[b]   = NW_WIDTH'(wid);
    b_taken[b] = taken;
    b_dest[b]  = dest;
  endtask

  task automatic expect_redir(input int wid, input logic [31:0] pc);
    redir_t e;
    e.wid = NW_WIDTH'(wid);
    e.pc  = pc;
    exp_q.push_back(e);
  endtask

  initial begin
    idle_inputs();
    redir_ready_i = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk_i);
    chk("rst_valid", 64'(redir_valid_o), 64'd0);
    chk("rst_mask", 64'(stalled_mask_o), 64'd0);
    chk("rst_err", 64'(protocol_err_o), 64'd0);

    // Taken branch on warp 3, redirect issued next cycle
    step(); stall(3);
    step(); idle_inputs();
    resolve(0, 3, 1'b1, 32'h2000_0040);
    expect_redir(3, 32'h2000_0040);
    redir_ready_i = 1'b1;
    @(negedge clk_i);
    chk("s1_wait_mask", 64'(stalled_mask_o), 64'h08);
    chk("s1_wait_valid", 64'(redir_valid_o), 64'd0);
    step(); idle_inputs();
    @(negedge clk_i);
    chk("s1_valid", 64'(redir_valid_o), 64'd1);
    chk("s1_wid", 64'(redir_wid_o), 64'd3);
    chk("s1_pc", 64'(redir_pc_o), 64'h2000_0040);
    step();
    @(negedge clk_i);
    chk("s1_mask_clr", 64'(stalled_mask_o[3]), 64'd0);
    chk("s1_valid_clr", 64'(redir_valid_o), 64'd0);

    // Not-taken branch on warp 1
    do_reset();
    step(); stall(1);
    step(); idle_inputs();
    resolve(0, 1, 1'b0, 32'hDEAD_BEE0);
    redir_ready_i = 1'b1;
    @(negedge clk_i);
    chk("s2_wait_mask", 64'(stalled_mask_o[1]), 64'd1);
    step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("s2_mask_clr", 64'(stalled_mask_o), 64'd0);
      chk("s2_no_redir", 64'(redir_valid_o), 64'd0);
      step();
    end

    // Three simultaneous taken branches, ready held low then high
    do_reset();
    step(); stall(0);
    step(); stall(2);
    step(); stall(5);
    step(); idle_inputs();
    resolve(0, 0, 1'b1, 32'h0000_1000);
    resolve(1, 2, 1'b1, 32'h0000_2000);
    resolve(2, 5, 1'b1, 32'h0000_5000);
    expect_redir(0, 32'h0000_1000);
    expect_redir(2, 32'h0000_2000);
    expect_redir(5, 32'h0000_5000);
    @(negedge clk_i);
    chk("s3_wait_mask", 64'(stalled_mask_o), 64'h25);
    step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("s3_hold_valid", 64'(redir_valid_o), 64'd1);
      chk("s3_hold_wid", 64'(redir_wid_o), 64'd0);
      chk("s3_hold_pc", 64'(redir_pc_o), 64'h1000);
      chk("s3_hold_mask", 64'(stalled_mask_o), 64'h25);
      step();
    end
    redir_ready_i = 1'b1;
    @(negedge clk_i); chk("s3_g0", 64'(redir_wid_o), 64'd0);
    step();
    @(negedge clk_i); chk("s3_g1", 64'(redir_wid_o), 64'd2);
    step();
    @(negedge clk_i); chk("s3_g2", 64'(redir_wid_o), 64'd5);
    step();
    @(negedge clk_i);
    chk("s3_done_valid", 64'(redir_valid_o), 64'd0);
    chk("s3_done_mask", 64'(stalled_mask_o), 64'd0);

    // Resolution for an idle warp is ignored and flagged
    do_reset();
    step(); resolve(0, 7, 1'b1, 32'h0000_1234);
    step(); idle_inputs();
    @(negedge clk_i);
    chk("s4_err", 64'(protocol_err_o), 64'd1);
    chk("s4_mask", 64'(stalled_mask_o), 64'd0);
    chk("s4_valid", 64'(redir_valid_o), 64'd0);
    repeat (4) step();
    @(negedge clk_i);
    chk("s4_err_sticky", 64'(protocol_err_o), 64'd1);
    do_reset();
    @(negedge clk_i);
    chk("s4_err_rst", 64'(protocol_err_o), 64'd0);

    // Two blocks resolving the same warp: lowest block wins
    step(); stall(2);
    step(); idle_inputs();
    resolve(0, 2, 1'b1, 32'h0000_0100);
    resolve(1, 2, 1'b1, 32'h0000_0200);
    expect_redir(2, 32'h0000_0100);
    redir_ready_i = 1'b1;
    @(negedge clk_i);
    chk("s5_err_pre", 64'(protocol_err_o), 64'd0);
    step(); idle_inputs();
    @(negedge clk_i);
    chk("s5_wid", 64'(redir_wid_o), 64'd2);
    chk("s5_pc", 64'(redir_pc_o), 64'h100);
    chk("s5_err", 64'(protocol_err_o), 64'd1);
    step();
    @(negedge clk_i);
    chk("s5_mask_clr", 64'(stalled_mask_o), 64'd0);

    // Stall and resolution collide on one warp: resolution applies
    do_reset();
    step(); stall(6);
    step(); idle_inputs();
    stall(6);
    resolve(0, 6, 1'b0, 32'h0);
    step(); idle_inputs();
    @(negedge clk_i);
    chk("s6_mask", 64'(stalled_mask_o), 64'd0);
    chk("s6_err", 64'(protocol_err_o), 64'd1);
    chk("s6_valid", 64'(redir_valid_o), 64'd0);

    // Asynchronous reset while warp 4 waits in REDIR
    do_reset();
    step(); stall(4);
    step(); idle_inputs();
    resolve(0, 4, 1'b1, 32'h0000_0ABC);
    step(); idle_inputs();
    @(negedge clk_i);
    chk("s7_valid_pre", 64'(redir_valid_o), 64'd1);
    chk("s7_mask_pre", 64'(stalled_mask_o), 64'h10);
    step();
    #2 rst_ni = 1'b0;
    #1;
    chk("s7_valid_async", 64'(redir_valid_o), 64'd0);
    chk("s7_mask_async", 64'(stalled_mask_o), 64'd0);
    chk("s7_err_async", 64'(protocol_err_o), 64'd0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
